// File: rtl/segre_pkg.sv
// Shared types and constants for the segre memory arbiter.
//   arb_state_e      : arbiter FSM states
//   arb_owner_e      : which stage owns the in-flight memory transaction
//   ARB_STARVE_LIMIT : default number of contested data wins before fetch wins
//   GNT_IF / GNT_DT  : bit positions in the one-hot grant vector
package segre_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE,
        ARB_REQ,
        ARB_RSP
    } arb_state_e;

    typedef enum logic {
        OWNER_IF,
        OWNER_DT
    } arb_owner_e;

    localparam int ARB_STARVE_LIMIT = 4;

    localparam int GNT_IF = 0;
    localparam int GNT_DT = 1;

endpackage

// File: rtl/segre_arb_prio.sv
// Priority selector with starvation protection for the memory arbiter.
//   clk_i, rsn_i : clock, asynchronous active-low reset
//   arb_en_i     : arbitration allowed this cycle (arbiter idle, out of reset)
//   if_req_i     : fetch request
//   dt_req_i     : data request
//   flush_i      : masks the fetch request for this cycle
//   gnt_o        : one-hot grant, bit GNT_IF = fetch, bit GNT_DT = data
module segre_arb_prio
    import segre_pkg::*;
#(
    parameter int STARVE_LIMIT = ARB_STARVE_LIMIT
) (
    input  logic       clk_i,
    input  logic       rsn_i,
    input  logic       arb_en_i,
    input  logic       if_req_i,
    input  logic       dt_req_i,
    input  logic       flush_i,
    output logic [1:0] gnt_o
);

    localparam logic [7:0] LIMIT = 8'(STARVE_LIMIT);

    logic [7:0] cnt_q, cnt_d;
    logic       if_eff, dt_eff, contest, if_win, dt_win;

    always_comb begin
        if_eff  = arb_en_i && if_req_i && !flush_i;
        dt_eff  = arb_en_i && dt_req_i;
        contest = if_eff && dt_eff;
        // Data wins a contest unless fetch has lost LIMIT contests in a row.
        if_win  = if_eff && (!dt_eff || (cnt_q == LIMIT));
        dt_win  = dt_eff && !if_win;

        gnt_o         = 2'b00;
        gnt_o[GNT_IF] = if_win;
        gnt_o[GNT_DT] = dt_win;

        cnt_d = cnt_q;
        if (if_win) begin
            cnt_d = 8'd0;
        end else if (dt_win && contest && (cnt_q != LIMIT)) begin
            cnt_d = cnt_q + 8'd1;
        end
    end

    always_ff @(posedge clk_i or negedge rsn_i) begin
        if (!rsn_i) begin
            cnt_q <= 8'd0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/segre_mem_arbiter.sv
// Shares one memory port between instruction fetch (read-only) and the data
// stage. One transaction at a time: grant in IDLE, hold the request in REQ
// until the memory accepts it, forward the response in RSP.
//   clk_i, rsn_i           : clock, asynchronous active-low reset
//   if_*                   : fetch request / grant / response
//   dt_*                   : data load/store request / grant / response
//   mem_*                  : memory port (request fields are registered)
//   flush_i                : drop any pending fetch response, mask fetch in IDLE
module segre_mem_arbiter
    import segre_pkg::*;
#(
    parameter int ADDR_SIZE    = 32,
    parameter int WORD_SIZE    = 32,
    parameter int STARVE_LIMIT = ARB_STARVE_LIMIT
) (
    input  logic                   clk_i,
    input  logic                   rsn_i,
    input  logic                   if_req_i,
    input  logic [ADDR_SIZE-1:0]   if_addr_i,
    output logic                   if_gnt_o,
    output logic                   if_rvalid_o,
    output logic [WORD_SIZE-1:0]   if_rdata_o,
    input  logic                   dt_req_i,
    input  logic                   dt_we_i,
    input  logic [WORD_SIZE/8-1:0] dt_be_i,
    input  logic [ADDR_SIZE-1:0]   dt_addr_i,
    input  logic [WORD_SIZE-1:0]   dt_wdata_i,
    output logic                   dt_gnt_o,
    output logic                   dt_rvalid_o,
    output logic [WORD_SIZE-1:0]   dt_rdata_o,
    output logic                   mem_req_o,
    output logic                   mem_we_o,
    output logic [WORD_SIZE/8-1:0] mem_be_o,
    output logic [ADDR_SIZE-1:0]   mem_addr_o,
    output logic [WORD_SIZE-1:0]   mem_wdata_o,
    input  logic                   mem_gnt_i,
    input  logic                   mem_rvalid_i,
    input  logic [WORD_SIZE-1:0]   mem_rdata_i,
    input  logic                   flush_i
);

    localparam int BE_W = WORD_SIZE / 8;

    arb_state_e             state_q;
    arb_owner_e             owner_q;
    logic                   drop_q;
    logic                   mem_req_q;
    logic                   mem_we_q;
    logic [BE_W-1:0]        mem_be_q;
    logic [ADDR_SIZE-1:0]   mem_addr_q;
    logic [WORD_SIZE-1:0]   mem_wdata_q;

    logic [1:0] gnt;
    logic       arb_en;

    // Gating with rsn_i keeps both grants low while reset is held.
    assign arb_en = (state_q == ARB_IDLE) && rsn_i;

    segre_arb_prio #(
        .STARVE_LIMIT (STARVE_LIMIT)
    ) u_prio (
        .clk_i    (clk_i),
        .rsn_i    (rsn_i),
        .arb_en_i (arb_en),
        .if_req_i (if_req_i),
        .dt_req_i (dt_req_i),
        .flush_i  (flush_i),
        .gnt_o    (gnt)
    );

    assign if_gnt_o = gnt[GNT_IF];
    assign dt_gnt_o = gnt[GNT_DT];

    always_ff @(posedge clk_i or negedge rsn_i) begin
        if (!rsn_i) begin
            state_q     <= ARB_IDLE;
            owner_q     <= OWNER_IF;
            drop_q      <= 1'b0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_be_q    <= '0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
        end else begin
            case (state_q)
                ARB_IDLE: begin
                    drop_q <= 1'b0;
                    if (gnt[GNT_IF]) begin
                        owner_q     <= OWNER_IF;
                        mem_req_q   <= 1'b1;
                        mem_we_q    <= 1'b0;
                        mem_be_q    <= '1;
                        mem_addr_q  <= if_addr_i;
                        mem_wdata_q <= '0;
                        state_q     <= ARB_REQ;
                    end else if (gnt[GNT_DT]) begin
                        owner_q     <= OWNER_DT;
                        mem_req_q   <= 1'b1;
                        mem_we_q    <= dt_we_i;
                        mem_be_q    <= dt_be_i;
                        mem_addr_q  <= dt_addr_i;
                        mem_wdata_q <= dt_wdata_i;
                        state_q     <= ARB_REQ;
                    end
                end
                ARB_REQ: begin
                    // The request cannot be retracted, so a flush only marks
                    // the fetch response to be swallowed.
                    if (flush_i && (owner_q == OWNER_IF)) begin
                        drop_q <= 1'b1;
                    end
                    if (mem_gnt_i) begin
                        mem_req_q <= 1'b0;
                        state_q   <= ARB_RSP;
                    end
                end
                ARB_RSP: begin
                    if (flush_i && (owner_q == OWNER_IF)) begin
                        drop_q <= 1'b1;
                    end
                    if (mem_rvalid_i) begin
                        drop_q  <= 1'b0;
                        state_q <= ARB_IDLE;
                    end
                end
                default: begin
                    state_q <= ARB_IDLE;
                end
            endcase
        end
    end

    assign mem_req_o   = mem_req_q;
    assign mem_we_o    = mem_we_q;
    assign mem_be_o    = mem_be_q;
    assign mem_addr_o  = mem_addr_q;
    assign mem_wdata_o = mem_wdata_q;

    // A flush arriving with the response also suppresses it.
    assign if_rvalid_o = (state_q == ARB_RSP) && mem_rvalid_i &&
                         (owner_q == OWNER_IF) && !drop_q && !flush_i;
    assign dt_rvalid_o = (state_q == ARB_RSP) && mem_rvalid_i &&
                         (owner_q == OWNER_DT);
    assign if_rdata_o  = mem_rdata_i;
    assign dt_rdata_o  = mem_rdata_i;

endmodule

// File: tb/tb_segre_mem_arbiter.sv
module tb_segre_mem_arbiter;

    localparam int AW    = 32;
    localparam int DW    = 32;
    localparam int LIMIT = 4;

    logic          clk_i = 1'b0;
    logic          rsn_i = 1'b0;
    logic          if_req_i = 1'b0;
    logic [AW-1:0] if_addr_i = '0;
    logic          if_gnt_o, if_rvalid_o;
    logic [DW-1:0] if_rdata_o;
    logic          dt_req_i = 1'b0, dt_we_i = 1'b0;
    logic [3:0]    dt_be_i = '0;
    logic [AW-1:0] dt_addr_i = '0;
    logic [DW-1:0] dt_wdata_i = '0;
    logic          dt_gnt_o, dt_rvalid_o;
    logic [DW-1:0] dt_rdata_o;
    logic          mem_req_o, mem_we_o;
    logic [3:0]    mem_be_o;
    logic [AW-1:0] mem_addr_o;
    logic [DW-1:0] mem_wdata_o;
    logic          mem_gnt_i = 1'b0, mem_rvalid_i = 1'b0;
    logic [DW-1:0] mem_rdata_i = '0;
    logic          flush_i = 1'b0;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk_i = ~clk_i;

    segre_mem_arbiter #(
        .ADDR_SIZE(AW), .WORD_SIZE(DW), .STARVE_LIMIT(LIMIT)
    ) dut (
        .clk_i(clk_i), .rsn_i(rsn_i),
        .if_req_i(if_req_i), .if_addr_i(if_addr_i), .if_gnt_o(if_gnt_o),
        .if_rvalid_o(if_rvalid_o), .if_rdata_o(if_rdata_o),
        .dt_req_i(dt_req_i), .dt_we_i(dt_we_i), .dt_be_i(dt_be_i),
        .dt_addr_i(dt_addr_i), .dt_wdata_i(dt_wdata_i), .dt_gnt_o(dt_gnt_o),
        .dt_rvalid_o(dt_rvalid_o), .dt_rdata_o(dt_rdata_o),
        .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_be_o(mem_be_o),
        .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o),
        .mem_gnt_i(mem_gnt_i), .mem_rvalid_i(mem_rvalid_i),
        .mem_rdata_i(mem_rdata_i), .flush_i(flush_i)
    );

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic clear_inputs();
        if_req_i = 0; if_addr_i = '0;
        dt_req_i = 0; dt_we_i = 0; dt_be_i = '0; dt_addr_i = '0; dt_wdata_i = '0;
        mem_gnt_i = 0; mem_rvalid_i = 0; mem_rdata_i = '0; flush_i = 0;
    endtask

    // Asserts reset between clock edges, holds it two edges, releases mid-cycle.
    task automatic apply_reset();
        @(posedge clk_i); #3;
        rsn_i = 0;
        clear_inputs();
        @(posedge clk_i); @(posedge clk_i); #3;
        rsn_i = 1;
        tick();
    endtask

    // Stimulus only: from REQ, accept immediately and answer the next cycle.
    task automatic serve_fast(input logic [DW-1:0] rdata);
        mem_gnt_i = 1;
        tick();
        mem_gnt_i = 0; mem_rvalid_i = 1; mem_rdata_i = rdata;
        tick();
        mem_rvalid_i = 0;
    endtask

    task automatic test_reset();
        rsn_i = 0;
        if_req_i = 1; dt_req_i = 1;
        #12;
        n_checks++;
        if ({if_gnt_o, dt_gnt_o} !== 2'b00) begin
            n_fail++; $display("FAIL reset_gnt: got %b required 00", {if_gnt_o, dt_gnt_o});
        end
        n_checks++;
        if ({mem_req_o, mem_we_o, mem_be_o, mem_addr_o, mem_wdata_o} !== '0) begin
            n_fail++; $display("FAIL reset_mem: req=%b we=%b be=%h addr=%h wdata=%h required all 0",
                               mem_req_o, mem_we_o, mem_be_o, mem_addr_o, mem_wdata_o);
        end
        clear_inputs();
        @(posedge clk_i); #3;
        rsn_i = 1;
        tick();
        $display("test_reset done");
    endtask

    task automatic test_fetch_only();
        if_req_i = 1; if_addr_i = 32'h100;
        #1;
        n_checks++;
        if ({if_gnt_o, dt_gnt_o} !== 2'b10) begin
            n_fail++; $display("FAIL fetch_gnt: got if=%b dt=%b required if=1 dt=0", if_gnt_o, dt_gnt_o);
        end
        tick();
        if_req_i = 0;
        for (int c = 0; c < 2; c++) begin
            mem_gnt_i = (c == 1);
            #1;
            n_checks++;
            if (mem_req_o !== 1'b1 || mem_addr_o !== 32'h100 || mem_we_o !== 1'b0 || mem_be_o !== 4'hF) begin
                n_fail++; $display("FAIL fetch_hold: req=%b addr=%h we=%b be=%h required 1 100 0 f",
                                   mem_req_o, mem_addr_o, mem_we_o, mem_be_o);
            end
            tick();
        end
        mem_gnt_i = 0;
        for (int c = 0; c < 3; c++) begin
            mem_rvalid_i = (c == 2);
            mem_rdata_i  = (c == 2) ? 32'hDEADBEEF : 32'h0;
            #1;
            n_checks++;
            if (mem_req_o !== 1'b0) begin
                n_fail++; $display("FAIL fetch_req_drop: got %b required 0", mem_req_o);
            end
            n_checks++;
            if (if_rvalid_o !== (c == 2) || dt_rvalid_o !== 1'b0) begin
                n_fail++; $display("FAIL fetch_rvalid: cyc %0d if=%b dt=%b required if=%b dt=0",
                                   c, if_rvalid_o, dt_rvalid_o, (c == 2));
            end
            tick();
        end
        n_checks++;
        if (if_rdata_o !== mem_rdata_i) begin
            n_fail++; $display("FAIL fetch_rdata: got %h required %h", if_rdata_o, mem_rdata_i);
        end
        clear_inputs();
        $display("test_fetch_only done");
    endtask

    task automatic test_contention();
        // Expected order from the rule: four data wins, then fetch, repeat.
        bit exp_if[10] = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 1};
        apply_reset();
        if_req_i = 1; if_addr_i = 32'h400;
        dt_req_i = 1; dt_addr_i = 32'h800;
        mem_gnt_i = 1; mem_rvalid_i = 1; mem_rdata_i = 32'h5;
        for (int g = 0; g < 10; g++) begin
            #1;
            n_checks++;
            if (if_gnt_o !== exp_if[g] || dt_gnt_o !== !exp_if[g]) begin
                n_fail++; $display("FAIL contention_grant[%0d]: got if=%b dt=%b required if=%b dt=%b",
                                   g, if_gnt_o, dt_gnt_o, exp_if[g], !exp_if[g]);
            end
            tick(); tick(); tick();
        end
        clear_inputs();
        tick();
        $display("test_contention done");
    endtask

    task automatic test_store();
        dt_req_i = 1; dt_we_i = 1; dt_be_i = 4'b0011;
        dt_addr_i = 32'h200; dt_wdata_i = 32'h1234;
        #1;
        n_checks++;
        if (dt_gnt_o !== 1'b1 || if_gnt_o !== 1'b0) begin
            n_fail++; $display("FAIL store_gnt: got dt=%b if=%b required dt=1 if=0", dt_gnt_o, if_gnt_o);
        end
        tick();
        clear_inputs();
        #1;
        n_checks++;
        if (mem_req_o !== 1 || mem_we_o !== 1 || mem_be_o !== 4'b0011 ||
            mem_addr_o !== 32'h200 || mem_wdata_o !== 32'h1234) begin
            n_fail++; $display("FAIL store_fields: req=%b we=%b be=%b addr=%h wdata=%h required 1 1 0011 200 1234",
                               mem_req_o, mem_we_o, mem_be_o, mem_addr_o, mem_wdata_o);
        end
        mem_gnt_i = 1;
        tick();
        mem_gnt_i = 0; mem_rvalid_i = 1;
        #1;
        n_checks++;
        if (dt_rvalid_o !== 1'b1 || if_rvalid_o !== 1'b0) begin
            n_fail++; $display("FAIL store_rvalid: got dt=%b if=%b required dt=1 if=0", dt_rvalid_o, if_rvalid_o);
        end
        tick();
        clear_inputs();
        $display("test_store done");
    endtask

    task automatic test_flush_rsp();
        if_req_i = 1; if_addr_i = 32'h300;
        tick();
        if_req_i = 0;
        mem_gnt_i = 1;
        tick();
        mem_gnt_i = 0; flush_i = 1;
        tick();
        flush_i = 0; mem_rvalid_i = 1; mem_rdata_i = 32'hCAFE;
        #1;
        n_checks++;
        if (if_rvalid_o !== 1'b0) begin
            n_fail++; $display("FAIL flush_drop: got if_rvalid=%b required 0", if_rvalid_o);
        end
        tick();
        mem_rvalid_i = 0;
        if_req_i = 1; if_addr_i = 32'h304;
        #1;
        n_checks++;
        if (if_gnt_o !== 1'b1) begin
            n_fail++; $display("FAIL flush_regrant: got if_gnt=%b required 1", if_gnt_o);
        end
        tick();
        if_req_i = 0;
        mem_gnt_i = 1;
        tick();
        mem_gnt_i = 0; mem_rvalid_i = 1; mem_rdata_i = 32'hBEEF;
        #1;
        n_checks++;
        if (if_rvalid_o !== 1'b1 || if_rdata_o !== 32'hBEEF) begin
            n_fail++; $display("FAIL flush_next_rsp: got rvalid=%b rdata=%h required 1 beef", if_rvalid_o, if_rdata_o);
        end
        tick();
        clear_inputs();
        $display("test_flush_rsp done");
    endtask

    task automatic test_flush_idle();
        if_req_i = 1; if_addr_i = 32'h500; flush_i = 1;
        #1;
        n_checks++;
        if (if_gnt_o !== 1'b0 || dt_gnt_o !== 1'b0) begin
            n_fail++; $display("FAIL flush_idle_mask: got if=%b dt=%b required 0 0", if_gnt_o, dt_gnt_o);
        end
        tick();
        flush_i = 0;
        #1;
        n_checks++;
        if (if_gnt_o !== 1'b1) begin
            n_fail++; $display("FAIL flush_idle_next: got if_gnt=%b required 1", if_gnt_o);
        end
        tick();
        if_req_i = 0;
        serve_fast(32'h1);
        $display("test_flush_idle done");
    endtask

    task automatic test_async_reset();
        dt_req_i = 1; dt_addr_i = 32'h600;
        tick();
        dt_req_i = 0;
        #1;
        n_checks++;
        if (mem_req_o !== 1'b1) begin
            n_fail++; $display("FAIL areset_pre: got mem_req=%b required 1", mem_req_o);
        end
        #1;
        rsn_i = 0;
        if_req_i = 1;
        #1;
        n_checks++;
        if (mem_req_o !== 1'b0 || mem_addr_o !== '0) begin
            n_fail++; $display("FAIL areset_immediate: got req=%b addr=%h required 0 0", mem_req_o, mem_addr_o);
        end
        n_checks++;
        if (if_gnt_o !== 1'b0) begin
            n_fail++; $display("FAIL areset_gnt: got if_gnt=%b required 0", if_gnt_o);
        end
        @(posedge clk_i); #3;
        if_req_i = 0;
        rsn_i = 1;
        tick();
        mem_rvalid_i = 1; mem_rdata_i = 32'h77;
        #1;
        n_checks++;
        if (if_rvalid_o !== 1'b0 || dt_rvalid_o !== 1'b0) begin
            n_fail++; $display("FAIL areset_stale: got if=%b dt=%b required 0 0", if_rvalid_o, dt_rvalid_o);
        end
        tick();
        clear_inputs();
        $display("test_async_reset done");
    endtask

    // Random traffic against a transaction-level model: at most one
    // outstanding transaction, tracked as "waiting for memory accept" or
    // "waiting for response", plus the count of contests fetch has lost.
    task automatic test_random();
        bit            busy = 0, accepted = 0, owner_dt = 0, dropped = 0;
        bit            t_we = 0;
        logic [3:0]    t_be = '0;
        logic [AW-1:0] t_addr = '0;
        logic [DW-1:0] t_wdata = '0;
        int            lost = 0;
        int            txns = 0;
        bit            e_if, e_dt, e_req, e_irv, e_drv, if_live;
        apply_reset();
        for (int cyc = 0; cyc < 3000; cyc++) begin
            if_req_i     = ($urandom_range(0, 1) == 1);
            if_addr_i    = $urandom;
            dt_req_i     = ($urandom_range(0, 1) == 1);
            dt_we_i      = ($urandom_range(0, 1) == 1);
            dt_be_i      = 4'($urandom);
            dt_addr_i    = $urandom;
            dt_wdata_i   = $urandom;
            flush_i      = ($urandom_range(0, 7) == 0);
            mem_gnt_i    = ($urandom_range(0, 1) == 1);
            mem_rvalid_i = ($urandom_range(0, 1) == 1);
            mem_rdata_i  = $urandom;
            #1;
            e_if = 0; e_dt = 0;
            if (!busy) begin
                if_live = if_req_i && !flush_i;
                if (if_live && dt_req_i) begin
                    e_if = (lost == LIMIT);
                    e_dt = !e_if;
                end else begin
                    e_if = if_live;
                    e_dt = dt_req_i;
                end
            end
            e_req = busy && !accepted;
            e_irv = busy && accepted && mem_rvalid_i && !owner_dt && !dropped && !flush_i;
            e_drv = busy && accepted && mem_rvalid_i && owner_dt;

            n_checks++;
            if (if_gnt_o !== e_if || dt_gnt_o !== e_dt) begin
                n_fail++; $display("FAIL rnd_gnt cyc %0d: got if=%b dt=%b required if=%b dt=%b",
                                   cyc, if_gnt_o, dt_gnt_o, e_if, e_dt);
            end
            n_checks++;
            if (mem_req_o !== e_req) begin
                n_fail++; $display("FAIL rnd_req cyc %0d: got %b required %b", cyc, mem_req_o, e_req);
            end
            if (e_req) begin
                n_checks++;
                if (mem_we_o !== t_we || mem_be_o !== t_be || mem_addr_o !== t_addr ||
                    (owner_dt && mem_wdata_o !== t_wdata)) begin
                    n_fail++; $display("FAIL rnd_fields cyc %0d: we=%b be=%h addr=%h wdata=%h required %b %h %h %h",
                                       cyc, mem_we_o, mem_be_o, mem_addr_o, mem_wdata_o,
                                       t_we, t_be, t_addr, t_wdata);
                end
            end
            n_checks++;
            if (if_rvalid_o !== e_irv || dt_rvalid_o !== e_drv) begin
                n_fail++; $display("FAIL rnd_rvalid cyc %0d: got if=%b dt=%b required if=%b dt=%b",
                                   cyc, if_rvalid_o, dt_rvalid_o, e_irv, e_drv);
            end
            if (e_irv || e_drv) begin
                n_checks++;
                if ((e_irv ? if_rdata_o : dt_rdata_o) !== mem_rdata_i) begin
                    n_fail++; $display("FAIL rnd_rdata cyc %0d: got %h required %h", cyc,
                                       (e_irv ? if_rdata_o : dt_rdata_o), mem_rdata_i);
                end
            end

            // Advance the model across the coming clock edge.
            if (!busy) begin
                if (e_if) begin
                    lost = 0;
                    busy = 1; accepted = 0; owner_dt = 0; dropped = 0;
                    t_we = 0; t_be = 4'hF; t_addr = if_addr_i; t_wdata = '0;
                end else if (e_dt) begin
                    if (if_req_i && !flush_i && lost < LIMIT) lost++;
                    busy = 1; accepted = 0; owner_dt = 1; dropped = 0;
                    t_we = dt_we_i; t_be = dt_be_i; t_addr = dt_addr_i; t_wdata = dt_wdata_i;
                end
            end else begin
                if (flush_i && !owner_dt) dropped = 1;
                if (!accepted) begin
                    if (mem_gnt_i) accepted = 1;
                end else if (mem_rvalid_i) begin
                    busy = 0;
                    txns++;
                end
            end
            tick();
        end
        clear_inputs();
        $display("test_random done: %0d transactions completed", txns);
    endtask

    initial begin
        clear_inputs();
        test_reset();
        test_fetch_only();
        test_contention();
        test_store();
        test_flush_rsp();
        test_flush_idle();
        test_async_reset();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
